// File: rtl/framing_pkg.sv
// framing_pkg
//   Shared definitions for the framing transmitter and the deframer:
//   frame-state encoding, CRC-16/X-25 constants and the SHR byte values.
//   Also provides a helper that returns the expected SHR byte for a
//   given byte index.
package framing_pkg;

  // Frame sequencing states, shared by transmit and receive sides
  typedef enum logic [2:0] {
    WAITING = 3'd0,
    SHR     = 3'd1,
    PHR     = 3'd2,
    PSDU    = 3'd3,
    FCS     = 3'd4
  } state_t;

  // CRC-16/X-25 register init and the bit-reversed polynomial 0x1021
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REFL = 16'h8408;

  // SHR = preamble bytes followed by the two start-of-frame delimiter bytes
  localparam logic [7:0] SHR_PREAMBLE = 8'hAA;
  localparam logic [7:0] SHR_SFD_0    = 8'h98;
  localparam logic [7:0] SHR_SFD_1    = 8'hF3;

  // Expected SHR byte for byte index bc, given the preamble length
  function automatic logic [7:0] shr_byte(input logic [7:0] bc,
                                          input logic [7:0] pre_bytes);
    logic [7:0] b;
    if (bc < pre_bytes) begin
      b = SHR_PREAMBLE;
    end else if (bc == pre_bytes) begin
      b = SHR_SFD_0;
    end else begin
      b = SHR_SFD_1;
    end
    return b;
  endfunction

endpackage

// File: rtl/crc16_x25_serial.sv
// crc16_x25_serial
//   Bit-serial CRC-16/X-25 register (reflected, LSB-first input).
//   Ports:
//     clk      - clock
//     reset_n  - synchronous active-low reset, loads CRC_INIT
//     clear    - reload CRC_INIT (start of a new frame)
//     enable   - shift one bit into the CRC this cycle
//     bit_in   - data bit to absorb
//     crc      - current 16-bit CRC register (not inverted)
module crc16_x25_serial
  import framing_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic        fb;
  logic [15:0] crc_next;

  // Feedback bit becomes the new MSB through the top bit of the
  // reflected polynomial, so a plain shift-and-xor covers it.
  always_comb begin
    fb       = bit_in ^ crc[0];
    crc_next = (crc >> 1) ^ (fb ? CRC_POLY_REFL : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/deframing_crc.sv
// deframing_crc
//   Receive-side deframer. Each byte is held on din for 8 clk cycles.
//   Verifies the SHR, latches the PHR length, forwards PHR+PSDU bytes
//   and checks the trailing FCS with a bit-serial CRC-16/X-25.
//   Ports:
//     clk            - bit clock, one data bit per cycle
//     reset_n        - synchronous active-low reset
//     din[7:0]       - received byte, stable for 8 cycles
//     indicator      - start pulse, one cycle before the first SHR cycle
//     dout[7:0]      - forwarded PHR/PSDU byte (din, zero when not valid)
//     dout_valid     - high during every PHR/PSDU cycle
//     next_indicator - pulse on the last FCS cycle
//     crc_ok         - FCS check result, held until the next frame start
//     frame_err      - pulse on SHR mismatch or illegal length
module deframing_crc
  import framing_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 127,
  parameter int unsigned PRE_BYTES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] din,
  input  logic       indicator,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       next_indicator,
  output logic       crc_ok,
  output logic       frame_err
);

  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [7:0] PRE_B      = 8'(PRE_BYTES);
  localparam logic [7:0] SHR_LAST_B = 8'(PRE_BYTES + 1);

  state_t      state, state_next;
  logic [2:0]  ph, ph_next;
  logic [7:0]  bc, bc_next;
  logic [7:0]  len, len_next;
  logic [7:0]  fcs_lo, fcs_lo_next;
  logic [7:0]  fcs_hi, fcs_hi_next;
  logic        crc_ok_q, crc_ok_next;

  logic        crc_clear;
  logic        crc_en;
  logic [15:0] crc;

  logic        valid_int;
  logic        err_int;
  logic        done_int;

  // CRC covers PHR and PSDU bits only, LSB of each byte first
  crc16_x25_serial u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (crc_clear),
    .enable  (crc_en),
    .bit_in  (din[ph]),
    .crc     (crc)
  );

  // State, counters and captured fields
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= WAITING;
      ph       <= 3'd0;
      bc       <= 8'd0;
      len      <= 8'd0;
      fcs_lo   <= 8'd0;
      fcs_hi   <= 8'd0;
      crc_ok_q <= 1'b0;
    end else begin
      state    <= state_next;
      ph       <= ph_next;
      bc       <= bc_next;
      len      <= len_next;
      fcs_lo   <= fcs_lo_next;
      fcs_hi   <= fcs_hi_next;
      crc_ok_q <= crc_ok_next;
    end
  end

  // Next-state and output decode. ph walks the 8 bit cycles of a byte;
  // bc counts bytes inside SHR/PSDU and the two FCS bytes.
  always_comb begin
    state_next  = state;
    ph_next     = ph;
    bc_next     = bc;
    len_next    = len;
    fcs_lo_next = fcs_lo;
    fcs_hi_next = fcs_hi;
    crc_ok_next = crc_ok_q;
    crc_clear   = 1'b0;
    crc_en      = 1'b0;
    valid_int   = 1'b0;
    err_int     = 1'b0;
    done_int    = 1'b0;

    unique case (state)
      WAITING: begin
        ph_next = 3'd0;
        bc_next = 8'd0;
        if (indicator) begin
          state_next  = SHR;
          crc_clear   = 1'b1;
          crc_ok_next = 1'b0;
        end
      end

      SHR: begin
        ph_next = ph + 3'd1;
        if (ph == 3'd0 && din != shr_byte(bc, PRE_B)) begin
          err_int    = 1'b1;
          state_next = WAITING;
          ph_next    = 3'd0;
          bc_next    = 8'd0;
        end else if (ph == 3'd7) begin
          if (bc == SHR_LAST_B) begin
            state_next = PHR;
            bc_next    = 8'd0;
          end else begin
            bc_next = bc + 8'd1;
          end
        end
      end

      PHR: begin
        valid_int = 1'b1;
        crc_en    = 1'b1;
        ph_next   = ph + 3'd1;
        // The length register is only valid from ph==1 onward, so the
        // range check uses din directly in the capture cycle.
        if (ph == 3'd0) begin
          len_next = din;
          if (din > MAX_LEN_B) begin
            err_int    = 1'b1;
            state_next = WAITING;
            ph_next    = 3'd0;
          end
        end else if (ph == 3'd7) begin
          bc_next    = 8'd0;
          state_next = (len == 8'd0) ? FCS : PSDU;
        end
      end

      PSDU: begin
        valid_int = 1'b1;
        crc_en    = 1'b1;
        ph_next   = ph + 3'd1;
        if (ph == 3'd7) begin
          if (bc == len - 8'd1) begin
            state_next = FCS;
            bc_next    = 8'd0;
          end else begin
            bc_next = bc + 8'd1;
          end
        end
      end

      FCS: begin
        ph_next = ph + 3'd1;
        // FCS arrives low byte first; the CRC register is frozen here
        if (ph == 3'd0) begin
          if (bc == 8'd0) begin
            fcs_lo_next = din;
          end else begin
            fcs_hi_next = din;
          end
        end
        if (ph == 3'd7) begin
          if (bc == 8'd1) begin
            done_int    = 1'b1;
            crc_ok_next = ({fcs_hi, fcs_lo} == ~crc);
            state_next  = WAITING;
            bc_next     = 8'd0;
          end else begin
            bc_next = bc + 8'd1;
          end
        end
      end

      default: begin
        state_next = WAITING;
        ph_next    = 3'd0;
        bc_next    = 8'd0;
      end
    endcase
  end

  // Pulses are suppressed while reset is held so an interrupted frame
  // never reports completion or an error.
  always_comb begin
    dout_valid     = valid_int;
    dout           = valid_int ? din : 8'h00;
    frame_err      = err_int & reset_n;
    next_indicator = done_int & reset_n;
    crc_ok         = crc_ok_q;
  end

endmodule

// File: tb/tb_deframing_crc.sv
// tb_deframing_crc
//   Directed self-checking bench for deframing_crc. Frames are driven
//   byte by byte (8 cycles per byte); a negedge monitor records dout,
//   pulses and their cycle numbers, and the main sequence checks them.
module tb_deframing_crc;

  logic       clk;
  logic       reset_n;
  logic [7:0] din;
  logic       indicator;
  logic [7:0] dout;
  logic       dout_valid;
  logic       next_indicator;
  logic       crc_ok;
  logic       frame_err;

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc       = 0;
  int shr_start = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int ni_cnt    = 0;
  int err_cyc   = 0;
  int ni_cyc    = 0;
  int base_valid, base_err, base_ni;

  logic [7:0] rx_q[$];
  logic [7:0] payload[0:255];

  deframing_crc #(.MAX_LEN(127), .PRE_BYTES(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .din            (din),
    .indicator      (indicator),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .next_indicator (next_indicator),
    .crc_ok         (crc_ok),
    .frame_err      (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record outputs mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (dout_valid) begin
      valid_cnt = valid_cnt + 1;
      rx_q.push_back(dout);
    end
    if (frame_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (next_indicator) begin
      ni_cnt = ni_cnt + 1;
      ni_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run = tests_run + 1;
    assert (observed === expected) else begin
      tests_failed = tests_failed + 1;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Hold one byte on din for its 8 bit cycles
  task automatic applyStimulus(input logic [7:0] b);
    din = b;
    repeat (8) tick();
  endtask

  // Reference FCS: byte-wise reflected CRC-16/X-25 over PHR + PSDU
  function automatic logic [15:0] fcs_of(input int len);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int i = 0; i <= len; i++) begin
      b = (i == 0) ? 8'(len) : payload[i-1];
      c = c ^ {8'h00, b};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // Snapshot counters, clear captured bytes, pulse indicator
  task automatic start_frame();
    base_valid = valid_cnt;
    base_err   = err_cnt;
    base_ni    = ni_cnt;
    rx_q.delete();
    indicator = 1'b1;
    tick();
    indicator = 1'b0;
    shr_start = cyc;
  endtask

  task automatic send_shr();
    for (int i = 0; i < 8; i++) applyStimulus(8'hAA);
    applyStimulus(8'h98);
    applyStimulus(8'hF3);
  endtask

  task automatic send_frame(input int len, input logic [7:0] lo, input logic [7:0] hi);
    start_frame();
    send_shr();
    applyStimulus(8'(len));
    for (int i = 0; i < len; i++) applyStimulus(payload[i]);
    applyStimulus(lo);
    applyStimulus(hi);
  endtask

  // Every PHR/PSDU byte must appear for exactly 8 valid cycles
  task automatic check_rx(input string tag, input int len);
    int bad;
    int k;
    logic [7:0] exp_b;
    bad = 0;
    checkOutput({tag, "_valid_cycles"}, 32'(rx_q.size()), 32'(8 * (len + 1)));
    for (int i = 0; i < rx_q.size(); i++) begin
      k = i / 8;
      if (k > len) begin
        bad = bad + 1;
      end else begin
        exp_b = (k == 0) ? 8'(len) : payload[k-1];
        if (rx_q[i] !== exp_b) bad = bad + 1;
      end
    end
    checkOutput({tag, "_bytes"}, 32'(bad), 32'd0);
  endtask

  task automatic fill_payload(input int len);
    for (int i = 0; i < len; i++) payload[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    logic [15:0] f;
    reset_n   = 1'b0;
    indicator = 1'b0;
    din       = 8'h00;
    repeat (3) tick();

    // Reset state
    checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_next_indicator", 32'(next_indicator), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst_crc_ok", 32'(crc_ok), 32'd0);
    reset_n = 1'b1;
    tick();

    // Empty PSDU, hand-computed FCS of PHR=0x00 is 0xF078
    send_frame(0, 8'h78, 8'hF0);
    check_rx("empty", 0);
    checkOutput("empty_ni_count", 32'(ni_cnt - base_ni), 32'd1);
    // Pulse lands in the 104th cycle counting the first SHR cycle as 1
    checkOutput("empty_ni_cycle", 32'(ni_cyc - shr_start + 1), 32'd104);
    checkOutput("empty_err", 32'(err_cnt - base_err), 32'd0);
    checkOutput("empty_crc_ok", 32'(crc_ok), 32'd1);

    // Same frame with a corrupted FCS low byte
    send_frame(0, 8'h79, 8'hF0);
    checkOutput("badfcs_ni_count", 32'(ni_cnt - base_ni), 32'd1);
    checkOutput("badfcs_err", 32'(err_cnt - base_err), 32'd0);
    checkOutput("badfcs_crc_ok", 32'(crc_ok), 32'd0);

    // Back-to-back frames with reference FCS, lengths 1, 5, 127
    fill_payload(1);
    f = fcs_of(1);
    send_frame(1, f[7:0], f[15:8]);
    check_rx("len1", 1);
    checkOutput("len1_crc_ok", 32'(crc_ok), 32'd1);

    fill_payload(5);
    f = fcs_of(5);
    send_frame(5, f[7:0], f[15:8]);
    check_rx("len5", 5);
    checkOutput("len5_crc_ok", 32'(crc_ok), 32'd1);
    checkOutput("len5_ni_cycle", 32'(ni_cyc - shr_start + 1), 32'(80 + 8 + 40 + 16));

    fill_payload(127);
    f = fcs_of(127);
    send_frame(127, f[7:0], f[15:8]);
    check_rx("len127", 127);
    checkOutput("len127_crc_ok", 32'(crc_ok), 32'd1);
    checkOutput("len127_ni_count", 32'(ni_cnt - base_ni), 32'd1);

    // SHR corruption: fourth preamble byte is 0xAB
    start_frame();
    for (int i = 0; i < 8; i++) applyStimulus((i == 3) ? 8'hAB : 8'hAA);
    applyStimulus(8'h98);
    applyStimulus(8'hF3);
    applyStimulus(8'h00);
    applyStimulus(8'h78);
    applyStimulus(8'hF0);
    checkOutput("shrerr_err_count", 32'(err_cnt - base_err), 32'd1);
    checkOutput("shrerr_err_cycle", 32'(err_cyc - shr_start), 32'd24);
    checkOutput("shrerr_valid", 32'(valid_cnt - base_valid), 32'd0);
    checkOutput("shrerr_ni", 32'(ni_cnt - base_ni), 32'd0);

    // Next frame after the corrupted one is received normally
    fill_payload(5);
    f = fcs_of(5);
    send_frame(5, f[7:0], f[15:8]);
    check_rx("after_shrerr", 5);
    checkOutput("after_shrerr_crc_ok", 32'(crc_ok), 32'd1);

    // Length 0x80 exceeds the maximum: abort in PHR cycle 0
    start_frame();
    send_shr();
    applyStimulus(8'h80);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("badlen_err_count", 32'(err_cnt - base_err), 32'd1);
    checkOutput("badlen_err_cycle", 32'(err_cyc - shr_start), 32'd80);
    checkOutput("badlen_valid", 32'(valid_cnt - base_valid), 32'd1);
    checkOutput("badlen_dout", 32'((rx_q.size() > 0) ? rx_q[0] : 8'h00), 32'h80);
    checkOutput("badlen_ni", 32'(ni_cnt - base_ni), 32'd0);
    checkOutput("badlen_crc_ok", 32'(crc_ok), 32'd0);

    // Good frame so crc_ok is 1 before the reset test
    fill_payload(1);
    f = fcs_of(1);
    send_frame(1, f[7:0], f[15:8]);
    checkOutput("prereset_crc_ok", 32'(crc_ok), 32'd1);

    // One-cycle reset in the middle of a PSDU byte
    fill_payload(5);
    f = fcs_of(5);
    start_frame();
    send_shr();
    applyStimulus(8'd5);
    applyStimulus(payload[0]);
    applyStimulus(payload[1]);
    din = payload[2];
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    checkOutput("midrst_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("midrst_dout", 32'(dout), 32'd0);
    checkOutput("midrst_crc_ok", 32'(crc_ok), 32'd0);
    checkOutput("midrst_frame_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    repeat (5) tick();
    applyStimulus(payload[3]);
    applyStimulus(payload[4]);
    applyStimulus(f[7:0]);
    applyStimulus(f[15:8]);
    checkOutput("midrst_ni", 32'(ni_cnt - base_ni), 32'd0);
    checkOutput("midrst_err", 32'(err_cnt - base_err), 32'd0);

    // Clean frame after the reset
    send_frame(5, f[7:0], f[15:8]);
    check_rx("postrst", 5);
    checkOutput("postrst_crc_ok", 32'(crc_ok), 32'd1);
    checkOutput("postrst_ni", 32'(ni_cnt - base_ni), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
